// File: rtl/riscv_structures.sv
// riscv_structures: shared memory-interface types and limits
package riscv_structures;
    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;
    localparam int DMEM_MAX_LATENCY = 15;
endpackage

// File: rtl/dmem_lfsr.sv
// dmem_lfsr: 8-bit Fibonacci LFSR (taps 8,6,5,4) with enable and synchronous reset to SEED
module dmem_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] q
);
    always_ff @(posedge clk)
        if (reset) q <= SEED;
        else if (en) q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave; DMEM_RANDOM_LAT_EN adds 0..3 random extra wait cycles
module dmem_responder
    import riscv_structures::*;
#(
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_ready,
    output logic [31:0] rsp_rdata,
    output logic        misalign
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, WAIT} state_e;
    state_e      state;
    logic [4:0]  cnt;
    logic        we_q;
    mem_size_e   size_q;
    logic        uns_q;
    logic [AW+1:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [DEPTH];
    logic [1:0]  extra;
    logic        done;
    logic        mis;
    logic [31:0] word;
    logic        unused_addr;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input mem_size_e sz,
                                             input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lane, 3'b000});
        h = 16'(w >> {lane[1], 4'b0000});
        return sz == MEM_B ? {{24{~uns & b[7]}}, b} :
               sz == MEM_H ? {{16{~uns & h[15]}}, h} : w;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input mem_size_e sz, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] data;
        mask = sz == MEM_B ? 32'h0000_00FF << {lane, 3'b000} :
               sz == MEM_H ? 32'h0000_FFFF << {lane[1], 4'b0000} : 32'hFFFF_FFFF;
        data = sz == MEM_B ? {4{wd[7:0]}} : sz == MEM_H ? {2{wd[15:0]}} : wd;
        return (old & ~mask) | (data & mask);
    endfunction

`ifdef DMEM_RANDOM_LAT_EN
    logic [7:0] lfsr;
    logic       unused_lfsr;
    dmem_lfsr u_lfsr (.clk(clk), .reset(reset), .en(1'b1), .q(lfsr));
    assign extra       = lfsr[1:0];
    assign unused_lfsr = ^lfsr[7:2];
`else
    assign extra = 2'd0;
`endif

    assign unused_addr = ^req_addr[31:AW+2];
    assign done      = state == WAIT && cnt == 5'd0;
    assign mis       = size_q == MEM_B ? 1'b0 : size_q == MEM_H ? addr_q[0] : |addr_q[1:0];
    assign word      = mem[addr_q[AW+1:2]];
    assign mem_ready = state == IDLE ? ~req_valid : done;
    assign misalign  = done & mis;
    assign rsp_rdata = done && !mis && !we_q ? load_ext(word, size_q, uns_q, addr_q[1:0]) : 32'd0;

    always_ff @(posedge clk)
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            size_q  <= MEM_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE) begin
            if (req_valid) begin
                state   <= WAIT;
                cnt     <= 5'(LATENCY - 1) + 5'(extra);
                we_q    <= req_we;
                size_q  <= mem_size_e'(req_size);
                uns_q   <= req_unsigned;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
            end
        end else if (cnt == 5'd0) begin
            state <= IDLE;
        end else begin
            cnt <= cnt - 5'd1;
        end

    // Array has no reset; a reset in the completion cycle still drops the store.
    always_ff @(posedge clk)
        if (!reset && done && we_q && !mis)
            mem[addr_q[AW+1:2]] <= store_merge(word, wdata_q, size_q, addr_q[1:0]);
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table, reset-in-WAIT sequence and randomized byte-model checks
module tb_dmem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
`ifdef DMEM_RANDOM_LAT_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_ready;
    logic [31:0] rsp_rdata;
    logic        misalign;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_ready(mem_ready), .rsp_rdata(rsp_rdata),
        .misalign(misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after completion.
    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic mis);
        int lat;
        bit done;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        rd = '0; mis = 1'b0; lat = 0; done = 1'b0;
        @(negedge clk);
        chk("ready_low_on_accept", 32'(mem_ready), 32'd0);
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            @(negedge clk);
            if (mem_ready) begin
                rd = rsp_rdata; mis = misalign; done = 1'b1;
            end else chk("misalign_during_stall", 32'(misalign), 32'd0);
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL timeout: mem_ready never rose for addr %h", a);
        end else if (lat < LAT || lat > LAT + EXTRA) begin
            fails++;
            $display("FAIL latency: got %0d cycles expected %0d..%0d", lat, LAT, LAT + EXTRA);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t        v[$];
    logic [7:0]  mb [256];
    logic [31:0] rd;
    logic        mis;

    initial begin
        v.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
        v.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
        v.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0});
        v.push_back('{1'b1, 2'd0, 1'b0, 32'h11, 32'h80, 32'h0, 1'b0});
        v.push_back('{1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0});
        v.push_back('{1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h00000080, 1'b0});
        v.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h11228044, 1'b0});
        v.push_back('{1'b1, 2'd1, 1'b0, 32'h13, 32'hBEEF, 32'h0, 1'b1});
        v.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h11228044, 1'b0});
        v.push_back('{1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1});
        v.push_back('{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h00001122, 1'b0});
        v.push_back('{1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'hFFFF8044, 1'b0});
        v.push_back('{1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h00008044, 1'b0});
        v.push_back('{1'b1, 2'd1, 1'b0, 32'h12, 32'hA5A5, 32'h0, 1'b0});
        v.push_back('{1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'hA5A58044, 1'b0});
        v.push_back('{1'b0, 2'd2, 1'b0, 32'h1010, 32'h0, 32'hA5A58044, 1'b0});
        v.push_back('{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0});
        v.push_back('{1'b0, 2'd3, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1});
        v.push_back('{1'b1, 2'd2, 1'b0, 32'h20, 32'h77, 32'h0, 1'b0});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(mem_ready), 32'd1);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_misalign", 32'(misalign), 32'd0);
        @(posedge clk); #1;

        foreach (v[i]) begin
            access(v[i].we, v[i].sz, v[i].uns, v[i].a, v[i].wd, rd, mis);
            chk($sformatf("vec%0d_misalign", i), 32'(mis), 32'(v[i].exp_mis));
            if (!v[i].we) chk($sformatf("vec%0d_rdata", i), rd, v[i].exp_rd);
            if (v[i].exp_mis) begin
                @(negedge clk);
                chk("misalign_after_completion", 32'(misalign), 32'd0);
                chk("ready_after_completion", 32'(mem_ready), 32'd1);
                @(posedge clk); #1;
            end
        end

        // Reset during WAIT of a store drops it.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'h5;
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wait_ready", 32'(mem_ready), 32'd1);
        chk("rst_wait_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, mis);
        chk("rst_wait_store_dropped", rd, 32'h77);

        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = $urandom;
            access(1'b1, 2'd2, 1'b0, 32'(4 * i), w, rd, mis);
            for (int k = 0; k < 4; k++) mb[4 * i + k] = w[8 * k +: 8];
        end

        for (int i = 0; i < 200; i++) begin
            logic [1:0]  sz;
            logic        we, uns, mis_e;
            logic [31:0] wd, val;
            int          a, n;
            sz  = 2'($urandom_range(0, 3));
            a   = int'($urandom_range(0, 255));
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            n   = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
            mis_e = (a % n) != 0;
            access(we, sz, uns, 32'(a), wd, rd, mis);
            chk($sformatf("rnd%0d_misalign", i), 32'(mis), 32'(mis_e));
            if (we && !mis_e)
                for (int k = 0; k < n; k++) mb[a + k] = wd[8 * k +: 8];
            if (!we) begin
                val = 32'd0;
                if (!mis_e) begin
                    for (int k = 0; k < n; k++) val = val | (32'(mb[a + k]) << (8 * k));
                    if (!uns && n < 4 && val[8 * n - 1]) val = val - (32'd1 << (8 * n));
                end
                chk($sformatf("rnd%0d_rdata", i), rd, val);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
